// File: rtl/nios2_pio_pkg.sv
// Shared constants for the Nios II PIO slaves: Avalon word addresses and CTRL/status bit positions.
package nios2_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_SET  = 2'd2;
    localparam logic [1:0] ADDR_CLR  = 2'd3;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int STAT_BUSY   = 0;

endpackage

// File: rtl/pio_pulse_stretch.sv
// Loadable down-counter: busy stays high for PULSE_CYCLES cycles after each load.
// A load while busy restarts the count, so back-to-back loads give one continuous pulse.
module pio_pulse_stretch #(
    parameter int PULSE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic busy
);

    localparam int CW = $clog2(PULSE_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= CW'(PULSE_CYCLES);
        else if (cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/nios2_pio_out.sv
// Avalon-MM output PIO: shadow register with set/clear, atomic commit to out_port,
// a fixed-length update strobe per commit, and a one-cycle registered readback path.
module nios2_pio_out
    import nios2_pio_pkg::*;
#(
    parameter int          WIDTH        = 32,
    parameter int          PULSE_CYCLES = 4,
    parameter logic [31:0] RESET_VALUE  = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             update_strobe
);

    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shadow_next;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      rd_next;
    logic             auto;
    logic             busy;
    logic             wr;
    logic             commit;

    assign wr    = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        shadow_next = shadow;
        case (address)
            ADDR_DATA: shadow_next = wdata;
            ADDR_SET:  shadow_next = shadow | wdata;
            ADDR_CLR:  shadow_next = shadow & ~wdata;
            default:   shadow_next = shadow;
        endcase
    end

    // CTRL commits on its own bit; data writes commit only under the pre-edge auto flag.
    assign commit = wr & ((address == ADDR_CTRL) ? writedata[CTRL_COMMIT] : auto);

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA: rd_next[WIDTH-1:0] = shadow;
            ADDR_CTRL: begin
                rd_next[CTRL_AUTO] = auto;
                rd_next[STAT_BUSY] = busy;
            end
            default:   rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow   <= RESET_VALUE[WIDTH-1:0];
            out_port <= RESET_VALUE[WIDTH-1:0];
            auto     <= 1'b0;
            readdata <= '0;
        end else begin
            readdata <= rd_next;
            if (wr)
                shadow <= shadow_next;
            if (wr && address == ADDR_CTRL)
                auto <= writedata[CTRL_AUTO];
            if (commit)
                out_port <= shadow_next;
        end
    end

    pio_pulse_stretch #(
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_pulse (
        .clk   (clk),
        .reset (reset),
        .load  (commit),
        .busy  (busy)
    );

    assign update_strobe = busy;

endmodule

// File: tb/tb_nios2_pio_out.sv
// Self-checking bench for nios2_pio_out: a 32-bit and an 8-bit instance share one bus and
// are checked every cycle against a register-map reference model, plus directed scenarios.
module tb_nios2_pio_out;

    localparam int          P  = 4;
    localparam logic [31:0] RV = 32'h5;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] rd32, rd8;
    logic [31:0] out32;
    logic [7:0]  out8;
    logic        stb32, stb8;

    always #5 clk = ~clk;

    nios2_pio_out #(.WIDTH(32), .PULSE_CYCLES(P), .RESET_VALUE(RV)) dut32 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd32),
        .out_port(out32), .update_strobe(stb32)
    );

    nios2_pio_out #(.WIDTH(8), .PULSE_CYCLES(P), .RESET_VALUE(RV)) dut8 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd8),
        .out_port(out8), .update_strobe(stb8)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: register contents plus the edge index of the last commit per instance.
    logic [31:0] m_mask   [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    logic [31:0] m_shadow [2];
    logic [31:0] m_out    [2];
    logic [31:0] m_rd     [2];
    logic        m_auto   [2];
    int          m_lc     [2] = '{-1000, -1000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic strobe_at(input int edge_idx, input int lc);
        return (edge_idx - lc >= 0) && (edge_idx - lc < P);
    endfunction

    task automatic step(input logic rst, input logic cs, input logic wn,
                        input logic [1:0] a, input logic [31:0] d);
        logic [31:0] nsh;
        logic        busy_pre;
        logic        com;
        reset      = rst;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            busy_pre = strobe_at(cyc - 1, m_lc[i]);
            if (rst) begin
                m_shadow[i] = RV & m_mask[i];
                m_out[i]    = RV & m_mask[i];
                m_auto[i]   = 1'b0;
                m_lc[i]     = -1000;
                m_rd[i]     = 32'h0;
            end else begin
                case (a)
                    2'd0:    m_rd[i] = m_shadow[i];
                    2'd1:    m_rd[i] = {30'h0, m_auto[i], busy_pre};
                    default: m_rd[i] = 32'h0;
                endcase
                if (cs && !wn) begin
                    case (a)
                        2'd0:    nsh = d & m_mask[i];
                        2'd2:    nsh = m_shadow[i] | (d & m_mask[i]);
                        2'd3:    nsh = m_shadow[i] & ~d & m_mask[i];
                        default: nsh = m_shadow[i];
                    endcase
                    com = (a == 2'd1) ? d[0] : m_auto[i];
                    if (a == 2'd1)
                        m_auto[i] = d[1];
                    m_shadow[i] = nsh;
                    if (com) begin
                        m_out[i] = nsh;
                        m_lc[i]  = cyc;
                    end
                end
            end
        end
        @(negedge clk);
        check("out32", out32, m_out[0]);
        check("stb32", {31'h0, stb32}, {31'h0, strobe_at(cyc, m_lc[0])});
        check("rd32",  rd32,  m_rd[0]);
        check("out8",  {24'h0, out8}, m_out[1]);
        check("stb8",  {31'h0, stb8}, {31'h0, strobe_at(cyc, m_lc[1])});
        check("rd8",   rd8,   m_rd[1]);
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 1'b1, 2'd2, 32'h0);
    endtask

    initial begin
        int  cnt;
        int  run;
        bit  done;

        // Reset for two cycles
        step(1'b1, 1'b0, 1'b1, 2'd0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 2'd0, 32'h0);
        check("rst_out", out32, 32'h5);
        check("rst_stb", {31'h0, stb32}, 32'h0);
        check("rst_rd",  rd32, 32'h0);

        // Manual commit
        step(1'b0, 1'b1, 1'b0, 2'd0, 32'h1234);
        step(1'b0, 1'b1, 1'b1, 2'd0, 32'h0);
        check("data_rb", rd32, 32'h1234);
        check("no_commit", out32, 32'h5);
        step(1'b0, 1'b1, 1'b0, 2'd1, 32'h1);
        check("commit_out", out32, 32'h1234);
        cnt = stb32 ? 1 : 0;
        repeat (7) begin
            idle();
            if (stb32) cnt++;
        end
        check("pulse_len", cnt, 4);

        // Auto commit with set/clear
        step(1'b0, 1'b1, 1'b0, 2'd1, 32'h2);
        check("auto_no_commit", out32, 32'h1234);
        step(1'b0, 1'b1, 1'b0, 2'd2, 32'hF0);
        check("set_out", out32, 32'h12F4);
        check("set_stb", {31'h0, stb32}, 32'h1);
        step(1'b0, 1'b1, 1'b0, 2'd3, 32'h34);
        check("clr_out", out32, 32'h12C0);
        repeat (6) idle();

        // Restart while busy: commit at N and N+2 gives one 6-cycle strobe
        run  = 0;
        done = 1'b0;
        step(1'b0, 1'b1, 1'b0, 2'd1, 32'h3);
        if (stb32) run++; else done = 1'b1;
        step(1'b0, 1'b1, 1'b1, 2'd1, 32'h0);
        check("busy_rb", rd32, 32'h3);
        if (!done) begin if (stb32) run++; else done = 1'b1; end
        step(1'b0, 1'b1, 1'b0, 2'd1, 32'h3);
        if (!done) begin if (stb32) run++; else done = 1'b1; end
        repeat (7) begin
            idle();
            if (!done) begin if (stb32) run++; else done = 1'b1; end
        end
        check("restart_len", run, 6);

        // Width masking on the 8-bit instance
        step(1'b0, 1'b1, 1'b0, 2'd0, 32'hABCD);
        step(1'b0, 1'b1, 1'b1, 2'd0, 32'h0);
        check("mask_rd8",  rd8,  32'h0000_00CD);
        check("mask_rd32", rd32, 32'h0000_ABCD);
        repeat (6) idle();

        // Reset during the strobe's second cycle
        step(1'b0, 1'b1, 1'b0, 2'd1, 32'h1);
        idle();
        check("mid_stb_hi", {31'h0, stb32}, 32'h1);
        step(1'b1, 1'b1, 1'b0, 2'd0, 32'h77);
        check("mid_rst_stb", {31'h0, stb32}, 32'h0);
        check("mid_rst_out", out32, 32'h5);
        check("mid_rst_out8", {24'h0, out8}, 32'h5);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] d;
            d = $urandom;
            if (($urandom % 3) == 0) d[0] = 1'b1;
            step(($urandom % 128) == 0, ($urandom % 4) != 0, ($urandom % 2) == 1,
                 2'($urandom % 4), d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
